// File: rtl/descr_pkg.sv
// descr_pkg: state encodings and default polynomial constants (x^7+x^6+1),
// shared with the transmit-side scrambler.
package descr_pkg;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;
   localparam int DEF_LFSR_LEN = 7;
   localparam int DEF_TAP_A    = 7;
   localparam int DEF_TAP_B    = 6;
endpackage

// File: rtl/descr_shift_reg.sv
// descr_shift_reg: received-bit delay line with shift enable and sync clear;
// exports the two feedback taps {s[TAP_A-1], s[TAP_B-1]}.
module descr_shift_reg
   import descr_pkg::*;
#(
   parameter int LEN   = DEF_LFSR_LEN,
   parameter int TAP_A = DEF_TAP_A,
   parameter int TAP_B = DEF_TAP_B
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       shift,
   input  logic       din,
   output logic [1:0] taps
);
   logic [LEN-1:0] s_q, s_d;
   always_comb s_d = clr ? '0 : shift ? {s_q[LEN-2:0], din} : s_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) s_q <= '0;
      else        s_q <= s_d;
   assign taps = {s_q[TAP_A-1], s_q[TAP_B-1]};
endmodule

// File: rtl/xor_descrambler.sv
// xor_descrambler: self-synchronising serial descrambler with lock FSM.
// Optional DESCR_ERR_CNT_EN adds chk_zero/err_cnt for all-zero-source BER checks.
module xor_descrambler
   import descr_pkg::*;
#(
   parameter int LFSR_LEN = DEF_LFSR_LEN,
   parameter int TAP_A    = DEF_TAP_A,
   parameter int TAP_B    = DEF_TAP_B
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef DESCR_ERR_CNT_EN
   input  logic        chk_zero,
   output logic [15:0] err_cnt,
`endif
   input  logic        en,
   input  logic        resync,
   input  logic        in_bit,
   input  logic        in_valid,
   output logic        out_bit,
   output logic        out_valid,
   output logic        locked
);
   localparam int FW = $clog2(LFSR_LEN);
   state_e          state_q, state_d;
   logic [FW-1:0]   fill_q, fill_d;
   logic            out_bit_q, out_bit_d, out_valid_q, out_valid_d;
   logic            acc, clr, last, lk, descr;
   logic [1:0]      taps;
   assign lk    = state_q == ST_LOCKED;
   assign acc   = en & ~resync & in_valid & (state_q != ST_IDLE);
   assign clr   = ~en | resync | (state_q == ST_IDLE);
   assign last  = fill_q == FW'(LFSR_LEN - 1);
   assign descr = in_bit ^ taps[1] ^ taps[0];
   descr_shift_reg #(.LEN(LFSR_LEN), .TAP_A(TAP_A), .TAP_B(TAP_B)) u_sr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .shift (acc),
      .din   (in_bit),
      .taps  (taps)
   );
   always_comb begin
      state_d     = !en ? ST_IDLE
                  : (resync || state_q == ST_IDLE) ? ST_SYNC
                  : (state_q == ST_SYNC && acc && last) ? ST_LOCKED
                  : state_q;
      fill_d      = (clr || (acc && last)) ? '0
                  : (acc && state_q == ST_SYNC) ? fill_q + 1'b1
                  : fill_q;
      out_valid_d = acc & lk;
      out_bit_d   = out_valid_d ? descr : out_bit_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         fill_q      <= '0;
         out_bit_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_q      <= fill_d;
         out_bit_q   <= out_bit_d;
         out_valid_q <= out_valid_d;
      end
   assign out_bit   = out_bit_q;
   assign out_valid = out_valid_q;
   assign locked    = lk;
`ifdef DESCR_ERR_CNT_EN
   logic [15:0] err_q, err_d;
   // Counted at acceptance alongside out_bit, so the count tracks emitted ones.
   always_comb err_d = (~en | resync) ? '0
                     : (acc && lk && chk_zero && descr && err_q != 16'hFFFF) ? err_q + 16'd1
                     : err_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) err_q <= '0;
      else        err_q <= err_d;
   assign err_cnt = err_q;
`endif
endmodule
